// File: rtl/struct_lane_regfile_if.sv
// Request/response bundle for struct_lane_regfile: write, read and clear channels.
// The CSR/control front end is the master; the register file is the slave.
interface struct_lane_regfile_if #(
    parameter int AW     = 2,
    parameter int LANES  = 8,
    parameter int LANE_W = 8,
    parameter int TAG_W  = 16
);
    localparam int DW = LANES * LANE_W;
    localparam int RW = DW + TAG_W;

    logic                    wr_valid;
    logic                    wr_ready;
    logic [AW-1:0]           wr_addr;
    logic signed [7:0]       wr_left;
    logic signed [7:0]       wr_right;
    logic                    wr_lane_en;
    logic [DW-1:0]           wr_data;
    logic                    wr_tag_en;
    logic [TAG_W-1:0]        wr_tag_mask;
    logic [TAG_W-1:0]        wr_tag;
    logic                    wr_err;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic [RW-1:0]           rd_data;
    logic                    rd_valid;
    logic                    clr;
    logic                    busy;

    modport master (
        output wr_valid, wr_addr, wr_left, wr_right, wr_lane_en, wr_data,
               wr_tag_en, wr_tag_mask, wr_tag, rd_en, rd_addr, clr,
        input  wr_ready, wr_err, rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_left, wr_right, wr_lane_en, wr_data,
               wr_tag_en, wr_tag_mask, wr_tag, rd_en, rd_addr, clr,
        output wr_ready, wr_err, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/struct_lane_regfile.sv
// Register file of packed {lanes, tag} records with run-time lane-range writes,
// masked tag writes, registered reads and a one-record-per-cycle clear sequencer.
module struct_lane_regfile #(
    parameter int DEPTH      = 4,
    parameter int LANES      = 8,
    parameter int LANE_W     = 8,
    parameter int TAG_W      = 16,
    parameter int LANE_ORDER = 0,
    parameter int LANE_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    struct_lane_regfile_if.slave  bus
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int DW = LANES * LANE_W;
    localparam int RW = DW + TAG_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic signed [31:0] IDX_LO   = 32'(LANE_BASE);
    localparam logic signed [31:0] IDX_HI   = 32'(LANE_BASE + LANES - 1);
    localparam logic [AW:0]        DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]      LAST_CNT = AW'(DEPTH - 1);

    // Physical lane position (0 = lowest lane bits) of a declared lane index.
    function automatic logic signed [31:0] lane_pos(input logic signed [31:0] idx);
        if (LANE_ORDER == 0)
            lane_pos = idx - IDX_LO;
        else
            lane_pos = 32'(LANES - 1) - (idx - IDX_LO);
    endfunction

    function automatic logic range_legal(input logic signed [31:0] l,
                                         input logic signed [31:0] r);
        logic in_rng;
        logic dir_ok;
        in_rng = (l >= IDX_LO) && (l <= IDX_HI) && (r >= IDX_LO) && (r <= IDX_HI);
        dir_ok = (LANE_ORDER == 0) ? (l >= r) : (l <= r);
        return in_rng && dir_ok;
    endfunction

    logic [RW-1:0]      mem [DEPTH];
    logic [0:0]         state;
    logic [AW-1:0]      cnt;

    logic signed [31:0] left_p0;
    logic signed [31:0] right_p0;
    logic signed [31:0] pos_lo_p0;
    logic signed [31:0] pos_hi_p0;
    logic               lane_ok_p0;
    logic               wr_fire_p0;
    logic               wr_addr_ok_p0;
    logic               rd_addr_ok_p0;
    logic [DW-1:0]      data_sh_p0;
    logic [RW-1:0]      old_p0;
    logic [RW-1:0]      new_p0;
    logic [TAG_W-1:0]   tag_p0;

    logic [RW-1:0]      rd_data_p1;
    logic               vld_p1;
    logic               wr_err_p1;

    // Stage p0: decode the request and build the merged record
    always_comb begin
        left_p0       = {{24{bus.wr_left[7]}}, bus.wr_left};
        right_p0      = {{24{bus.wr_right[7]}}, bus.wr_right};
        wr_addr_ok_p0 = ({1'b0, bus.wr_addr} < DEPTH_C);
        rd_addr_ok_p0 = ({1'b0, bus.rd_addr} < DEPTH_C);
        wr_fire_p0    = bus.wr_valid && (state == ST_IDLE);
        lane_ok_p0    = bus.wr_lane_en && range_legal(left_p0, right_p0);
        pos_lo_p0     = lane_pos(right_p0);
        pos_hi_p0     = lane_pos(left_p0);
        data_sh_p0    = lane_ok_p0 ? (bus.wr_data << (LANE_W * pos_lo_p0[15:0])) : '0;
        old_p0        = wr_addr_ok_p0 ? mem[bus.wr_addr] : '0;

        new_p0 = old_p0;
        for (int p = 0; p < LANES; p++) begin
            if (lane_ok_p0 && (p >= pos_lo_p0) && (p <= pos_hi_p0))
                new_p0[TAG_W + p*LANE_W +: LANE_W] = data_sh_p0[p*LANE_W +: LANE_W];
        end

        tag_p0 = old_p0[TAG_W-1:0];
        if (bus.wr_tag_en)
            tag_p0 = (tag_p0 & ~bus.wr_tag_mask) | (bus.wr_tag & bus.wr_tag_mask);
        new_p0[TAG_W-1:0] = tag_p0;
    end

    // Stage p1: commit writes/clears, register read data and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            vld_p1     <= 1'b0;
            wr_err_p1  <= 1'b0;
            rd_data_p1 <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            vld_p1 <= bus.rd_en;
            if (bus.rd_en)
                rd_data_p1 <= rd_addr_ok_p0 ? mem[bus.rd_addr] : '0;

            wr_err_p1 <= wr_fire_p0 && wr_addr_ok_p0 && bus.wr_lane_en && !lane_ok_p0;
            if (wr_fire_p0 && wr_addr_ok_p0)
                mem[bus.wr_addr] <= new_p0;

            case (state)
                ST_IDLE: begin
                    if (bus.clr) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST_CNT)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_ready = (state == ST_IDLE);
    assign bus.busy     = (state == ST_CLEAR);
    assign bus.wr_err   = wr_err_p1;
    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_valid = vld_p1;
endmodule
